// File: rtl/filter_package.sv
// Sample and tap formats shared by the TX FIR driver and the RX equalizer.
package filter_package;

    localparam int FILTER_OUT_WIDTH = 12;
    localparam int TAP_WIDTH        = 8;

    typedef logic signed [FILTER_OUT_WIDTH-1:0] FILTER_OUT_FORMAT;
    typedef logic signed [TAP_WIDTH-1:0]        TAP_FORMAT;

endpackage

// File: rtl/rx_package.sv
// RX equalizer constants: DFE tap table, lock margins, equalized-sample format.
package rx_package;
    import filter_package::*;

    localparam int N_DFE_TAPS     = 4;
    localparam int N_DFE_SETTINGS = 12;
    localparam int EQ_WIDTH       = FILTER_OUT_WIDTH + $clog2(N_DFE_TAPS) + 2;

    typedef logic signed [EQ_WIDTH-1:0] EQ_FORMAT;
    typedef logic        [EQ_WIDTH-1:0] MAG_FORMAT;

    typedef enum logic {ACQUIRE, TRACK} lock_state_t;

    // Rows 0 and 1 are pinned to the values the bring-up vectors rely on.
    localparam TAP_FORMAT DFE_TAPS [N_DFE_SETTINGS][N_DFE_TAPS] = '{
        '{8'sd0,  8'sd0,  8'sd0,  8'sd0},
        '{8'sd64, 8'sd16, 8'sd0,  8'sd0},
        '{8'sd8,  8'sd0,  8'sd0,  8'sd0},
        '{8'sd16, 8'sd4,  8'sd0,  8'sd0},
        '{8'sd24, 8'sd8,  8'sd2,  8'sd0},
        '{8'sd32, 8'sd12, 8'sd4,  8'sd0},
        '{8'sd40, 8'sd16, 8'sd6,  8'sd2},
        '{8'sd48, 8'sd20, 8'sd8,  8'sd2},
        '{8'sd56, 8'sd24, 8'sd10, 8'sd4},
        '{8'sd64, 8'sd28, 8'sd12, 8'sd4},
        '{8'sd40, 8'sd20, 8'sd10, 8'sd5},
        '{8'sd80, 8'sd32, 8'sd16, 8'sd8}
    };

    localparam MAG_FORMAT LOCK_MARGIN [N_DFE_SETTINGS] = '{
        16'd32, 16'd32, 16'd32, 16'd40, 16'd48, 16'd48,
        16'd56, 16'd56, 16'd64, 16'd64, 16'd64, 16'd80
    };

    function automatic EQ_FORMAT tap_ext(input int s, input int k);
        return EQ_FORMAT'(DFE_TAPS[s][k]);
    endfunction

endpackage

// File: rtl/rx_lock_fsm.sv
// Margin-based lock tracker: LOCK_COUNT good samples in a row lock,
// UNLOCK_COUNT bad samples in a row drop lock.
module rx_lock_fsm
    import rx_package::*;
#(
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic good,
    output logic lock
);

    localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);

    lock_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACQUIRE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The counter always tracks the run length of the sample kind that would
    // cause the next state change; the opposite kind restarts the run.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lock     = (state == TRACK);
        if (valid) begin
            unique case (state)
                ACQUIRE: begin
                    if (!good) begin
                        cnt_nx = '0;
                    end else if (cnt == LOCK_LAST) begin
                        state_nx = TRACK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                TRACK: begin
                    if (good) begin
                        cnt_nx = '0;
                    end else if (cnt == UNLOCK_LAST) begin
                        state_nx = ACQUIRE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = ACQUIRE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rx_dfe_slicer.sv
// Decision-feedback equalizer, slicer and lock tracking for the RX path.
// Optional eye-margin monitor enabled by defining RX_EYE_MON_EN.
module rx_dfe_slicer
    import filter_package::*;
    import rx_package::*;
#(
    parameter int setting      = 10,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  FILTER_OUT_FORMAT in,
    input  logic             in_valid,
    output logic             out,
    output logic             out_valid,
    output logic             lock
`ifdef RX_EYE_MON_EN
    ,
    output EQ_FORMAT         eye_min
`endif
);

    logic [N_DFE_TAPS-1:0] hist_bit;
    logic [N_DFE_TAPS-1:0] hist_vld;
    EQ_FORMAT              fb;
    EQ_FORMAT              eq;
    MAG_FORMAT             mag;
    logic                  dec;
    logic                  good;

    // Feedback is purely combinational from the history registers so that a
    // decision feeds the very next sample even when samples are back-to-back.
    always_comb begin
        fb = '0;
        for (int k = 0; k < N_DFE_TAPS; k++) begin
            if (hist_vld[k]) begin
                fb = hist_bit[k] ? (fb + tap_ext(setting, k)) : (fb - tap_ext(setting, k));
            end
        end
        eq   = EQ_FORMAT'(in) - fb;
        dec  = ~eq[EQ_WIDTH-1];
        mag  = eq[EQ_WIDTH-1] ? MAG_FORMAT'(-eq) : MAG_FORMAT'(eq);
        good = (mag >= LOCK_MARGIN[setting]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_bit  <= '0;
            hist_vld  <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                hist_bit <= {hist_bit[N_DFE_TAPS-2:0], dec};
                hist_vld <= {hist_vld[N_DFE_TAPS-2:0], 1'b1};
                out      <= dec;
            end
        end
    end

    rx_lock_fsm #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock_fsm (
        .clk   (clk),
        .rst   (rst),
        .valid (in_valid),
        .good  (good),
        .lock  (lock)
    );

`ifdef RX_EYE_MON_EN
    localparam MAG_FORMAT EYE_INIT = {1'b0, {(EQ_WIDTH-1){1'b1}}};

    logic [9:0] win_cnt;
    MAG_FORMAT  win_min;
    MAG_FORMAT  win_next;

    always_comb begin
        win_next = (mag < win_min) ? mag : win_min;
    end

    // Only valid samples advance the 1024-sample window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            win_min <= EYE_INIT;
            eye_min <= EQ_FORMAT'(EYE_INIT);
        end else if (in_valid) begin
            win_cnt <= win_cnt + 10'd1;
            if (win_cnt == 10'd1023) begin
                eye_min <= EQ_FORMAT'(win_next);
                win_min <= EYE_INIT;
            end else begin
                win_min <= win_next;
            end
        end
    end
`endif

endmodule
